fxp_mult_pipe: RTL and testbench

- Parametrised, pipelined fixed-point multiplier.
- Next generation of the team's combinational Q5.11 multiplier used in the cosine datapath.
- Adds configurable width and fraction bits, signed mode, rounding, saturation with overflow flag, and a valid/ready pipeline with full backpressure.
- Sits between the angle-reduction and series-accumulation stages of the cosine engine.

---
 rtl/fxp_mult_pipe_if.sv | 9 +
 rtl/fxp_mult_pipe.sv | 64 ++++++
 tb/tb_fxp_mult_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fxp_mult_pipe_if.sv
// fxp_mult_pipe_if: operand/result valid-ready bus of the pipelined fixed-point multiplier
interface fxp_mult_pipe_if #(
  parameter int WIDTH = 16
);
  logic in_valid, in_ready, out_valid, out_ready, overflow;
  logic [WIDTH-1:0] a, b, result;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result, overflow);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, result, overflow);
endinterface

// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe: pipelined Q(WIDTH-FRAC).FRAC multiplier with rounding, saturation and backpressure
module fxp_mult_pipe #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 11,
  parameter int STAGES   = 2,
  parameter int SIGNED   = 0,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input logic clk,
  input logic rst_n,
  fxp_mult_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int HW = PW - FRAC;
  localparam logic [PW-1:0] RND = ROUND != 0 ? PW'(1) << (FRAC - 1) : '0;
  logic [STAGES-1:0] v, adv;
  logic [STAGES:0] vcat;
  logic [PW-1:0] ea, eb, prod, fin_in;
  logic [HW-1:0] hi;
  logic [HW-WIDTH:0] top;
  logic ovf_c, ovf_q;
  logic [WIDTH-1:0] res_c, res_q;
  assign ea = {{WIDTH{SIGNED != 0 && bus.a[WIDTH-1]}}, bus.a};
  assign eb = {{WIDTH{SIGNED != 0 && bus.b[WIDTH-1]}}, bus.b};
  assign prod = ea * eb;
  assign vcat = {v, bus.in_valid};
  // a stage may load when it or any stage downstream of it is empty, or the sink is taking
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) adv[k] = bus.out_ready || (~v >> k) != '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) v <= '0;
    else for (int k = 0; k < STAGES; k++) if (adv[k]) v[k] <= vcat[k];
  generate
    if (STAGES == 1) begin : g_one
      assign fin_in = prod;
    end else begin : g_pipe
      logic [PW-1:0] p [STAGES-1];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int k = 0; k < STAGES - 1; k++) p[k] <= '0;
        else begin
          if (adv[0]) p[0] <= prod;
          for (int k = 1; k < STAGES - 1; k++) if (adv[k]) p[k] <= p[k-1];
        end
      assign fin_in = p[STAGES-2];
    end
  endgenerate
  // hi is the shifted product; its top bit acts as the sign when SIGNED
  assign hi = HW'((fin_in + RND) >> FRAC);
  assign top = hi[HW-1:WIDTH-1];
  assign ovf_c = SIGNED != 0 ? !(&top || !(|top)) : |top[HW-WIDTH:1];
  assign res_c = ovf_c && SATURATE != 0
    ? (SIGNED != 0 ? {hi[HW-1], {(WIDTH-1){!hi[HW-1]}}} : '1)
    : hi[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {ovf_q, res_q} <= '0;
    else if (adv[STAGES-1]) {ovf_q, res_q} <= {ovf_c, res_c};
  assign bus.in_ready = rst_n && adv[0];
  assign bus.out_valid = v[STAGES-1];
  assign bus.result = res_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb_fxp_mult_pipe: vector table, scoreboarded random traffic, backpressure and reset checks
module tb_fxp_mult_pipe;
  localparam int N = 6;
  localparam int ST [N] = '{2, 2, 2, 2, 3, 1};
  localparam int SG [N] = '{0, 0, 0, 1, 1, 0};
  localparam int RD [N] = '{1, 0, 0, 1, 0, 1};
  localparam int SA [N] = '{1, 1, 0, 1, 0, 1};
  typedef struct {
    int d;
    logic [15:0] a, b, r;
    logic o;
  } vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [15:0] a = 0, b = 0;
  logic [N-1:0] ir, ov, of;
  logic [15:0] res [N];
  logic [16:0] q [N][$];
  int pops [N] = '{default: 0};
  int n_chk = 0, n_fail = 0;
  logic acc0 = 0;
  vec_t tv [16];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    fxp_mult_pipe_if #(.WIDTH(16)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.a = a;
    assign bus.b = b;
    assign bus.out_ready = out_ready;
    assign ir[g] = bus.in_ready;
    assign ov[g] = bus.out_valid;
    assign of[g] = bus.overflow;
    assign res[g] = bus.result;
    fxp_mult_pipe #(.WIDTH(16), .FRAC(11), .STAGES(ST[g]), .SIGNED(SG[g]), .ROUND(RD[g]),
      .SATURATE(SA[g])) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end
  // plain integer arithmetic on the real-valued meaning of the Q5.11 operands
  function automatic logic [16:0] model(int sg, int rd, int sa, logic [15:0] x, logic [15:0] y);
    longint p, s;
    logic o;
    p = (sg != 0 ? longint'($signed(x)) : longint'(x)) * (sg != 0 ? longint'($signed(y)) : longint'(y));
    if (rd != 0) p += 1024;
    s = p >>> 11;
    o = sg != 0 ? (s > 32767 || s < -32768) : (s > 65535);
    return {o, o && sa != 0 ? (sg != 0 ? (s < 0 ? 16'h8000 : 16'h7FFF) : 16'hFFFF) : s[15:0]};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic sb();
    for (int i = 0; i < N; i++) begin
      if (ov[i] && out_ready) begin
        if (q[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb%0d: got unexpected result %h expected no output", i, res[i]);
        end else check($sformatf("sb%0d", i), {of[i], res[i]}, q[i].pop_front());
        pops[i]++;
      end
      if (in_valid && ir[i]) q[i].push_back(model(SG[i], RD[i], SA[i], a, b));
    end
    acc0 = in_valid && ir[0];
  endtask
  task automatic tick();
    @(negedge clk);
    sb();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k, c, p0;
    tv[0]  = '{0, 16'h1800, 16'h1800, 16'h4800, 1'b0};
    tv[1]  = '{0, 16'h0E00, 16'h1900, 16'h2BC0, 1'b0};
    tv[2]  = '{0, 16'h0001, 16'h0400, 16'h0001, 1'b0};
    tv[3]  = '{0, 16'h8000, 16'h1000, 16'hFFFF, 1'b1};
    tv[4]  = '{1, 16'h0E00, 16'h1900, 16'h2BC0, 1'b0};
    tv[5]  = '{1, 16'h0001, 16'h0400, 16'h0000, 1'b0};
    tv[6]  = '{2, 16'h8000, 16'h1000, 16'h0000, 1'b1};
    tv[7]  = '{2, 16'h1800, 16'h1800, 16'h4800, 1'b0};
    tv[8]  = '{3, 16'hF800, 16'h1800, 16'hE800, 1'b0};
    tv[9]  = '{3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
    tv[10] = '{3, 16'hFFFF, 16'h0400, 16'h0000, 1'b0};
    tv[11] = '{3, 16'h8000, 16'h1000, 16'h8000, 1'b1};
    tv[12] = '{4, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    tv[13] = '{4, 16'hFFFF, 16'h0400, 16'hFFFF, 1'b0};
    tv[14] = '{4, 16'hF800, 16'h1800, 16'hE800, 1'b0};
    tv[15] = '{5, 16'h1800, 16'h1800, 16'h4800, 1'b0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", ov, 0);
    check("rst_overflow", of, 0);
    check("rst_in_ready", ir, 0);
    for (int i = 0; i < N; i++) check($sformatf("rst_result%0d", i), res[i], 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    out_ready = 1;
    for (int t = 0; t < 16; t++) begin
      repeat (3) tick();
      a = tv[t].a;
      b = tv[t].b;
      in_valid = 1;
      tick();
      in_valid = 0;
      for (int j = 0; j < ST[tv[t].d] - 1; j++) begin
        @(negedge clk);
        check($sformatf("vec%0d_early", t), ov[tv[t].d], 0);
        sb();
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      check($sformatf("vec%0d_valid", t), ov[tv[t].d], 1);
      check($sformatf("vec%0d_result", t), res[tv[t].d], tv[t].r);
      check($sformatf("vec%0d_overflow", t), of[tv[t].d], tv[t].o);
      sb();
      @(posedge clk);
      #1;
    end
    for (int t = 0; t < 400; t++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a = $urandom_range(0, 1) != 0 ? 16'($urandom) : 16'($urandom_range(0, 16'h2000));
      b = $urandom_range(0, 1) != 0 ? 16'($urandom) : 16'($urandom_range(0, 16'h2000));
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (6) tick();
    for (int i = 0; i < N; i++) check($sformatf("drain%0d", i), q[i].size(), 0);
    p0 = pops[0];
    k = 0;
    c = 0;
    while (k < 8 && c < 200) begin
      a = 16'h0100 * 16'(k + 1);
      b = 16'h0900 + 16'(k);
      in_valid = 1;
      out_ready = !(c >= 3 && c < 8);
      @(negedge clk);
      if (c == 6) begin
        check("stall_in_ready", ir[0], 0);
        check("stall_out_valid", ov[0], 1);
      end
      sb();
      @(posedge clk);
      #1;
      c++;
      if (acc0) k++;
    end
    check("stream_accepted", k, 8);
    in_valid = 0;
    out_ready = 1;
    repeat (5) tick();
    check("stream_count", pops[0] - p0, 8);
    check("stream_empty", q[0].size(), 0);
    in_valid = 1;
    repeat (4) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
    end
    rst_n = 0;
    #1;
    check("midrst_out_valid", ov, 0);
    check("midrst_in_ready", ir, 0);
    for (int i = 0; i < N; i++) q[i].delete();
    repeat (2) tick();
    rst_n = 1;
    in_valid = 0;
    repeat (5) begin
      @(negedge clk);
      check("postrst_idle", ov, 0);
      sb();
      @(posedge clk);
      #1;
    end
    in_valid = 1;
    repeat (6) begin
      a = 16'($urandom_range(0, 16'h3000));
      b = 16'($urandom_range(0, 16'h3000));
      tick();
    end
    in_valid = 0;
    repeat (6) tick();
    for (int i = 0; i < N; i++) check($sformatf("final_drain%0d", i), q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
